ipb_modport_slave: RTL and testbench

- IPbus-style slave register bank exercised through the slave side of the ipb_if bus interface.
- Accepts single-word read/write transactions (strobe/write/addr/wdata) and answers with a one-cycle ack or error pulse plus rdata.
- Holds NREGS read/write control registers and one read-only ID word, and exports all control registers as a flat bus to downstream fabric logic.

---
 rtl/ipb_modport_slave.sv | 85 ++++++++
 tb/tb_ipb_modport_slave.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/ipb_modport_slave.sv
// ipb_modport_slave
//   IPbus-style slave register bank. Serves single-word read/write
//   transactions with a registered one-cycle ack or error pulse, holds
//   NREGS read/write control registers plus one read-only ID word at
//   address NREGS, and exports the control registers as a flat bus.
//
// Ports
//   clk       sole clock, rising edge
//   rst       synchronous active-high reset
//   strobe    transaction request, held by the master until a response
//   write     1 = write, 0 = read (valid while strobe is high)
//   addr      word address, decoded over the full AWIDTH bits
//   wdata     write data
//   ack       one-cycle success pulse
//   error     one-cycle failure pulse
//   rdata     read data, valid while ack is high, 0 otherwise
//   regs_out  register i at bits [i*DWIDTH +: DWIDTH]
module ipb_modport_slave #(
  parameter int                DWIDTH   = 32,
  parameter int                AWIDTH   = 32,
  parameter int                NREGS    = 16,
  parameter logic [DWIDTH-1:0] ID_VALUE = 32'hA5C3_0001
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      strobe,
  input  logic                      write,
  input  logic [AWIDTH-1:0]         addr,
  input  logic [DWIDTH-1:0]         wdata,
  output logic                      ack,
  output logic                      error,
  output logic [DWIDTH-1:0]         rdata,
  output logic [NREGS*DWIDTH-1:0]   regs_out
);

  localparam logic [AWIDTH-1:0] ID_ADDR = AWIDTH'(NREGS);

  logic [DWIDTH-1:0] regs [NREGS];

  logic              is_reg;
  logic              is_id;
  logic              valid;
  logic              busy;
  logic              ack_d;
  logic              error_d;
  logic [DWIDTH-1:0] rd_mux;

  always_comb begin
    is_reg  = (addr < ID_ADDR);
    is_id   = (addr == ID_ADDR);
    valid   = is_reg | (is_id & ~write);
    // A master may keep strobe high for a cycle after seeing the response;
    // blocking on the previous response keeps that from re-triggering.
    busy    = ack | error;
    ack_d   = strobe & valid & ~busy;
    error_d = strobe & ~valid & ~busy;

    rd_mux = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (addr == AWIDTH'(i)) rd_mux = regs[i];
    end
    if (is_id) rd_mux = ID_VALUE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack   <= 1'b0;
      error <= 1'b0;
      rdata <= '0;
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      ack   <= ack_d;
      error <= error_d;
      rdata <= (ack_d & ~write) ? rd_mux : '0;
      for (int unsigned i = 0; i < NREGS; i++) begin
        if (ack_d && write && addr == AWIDTH'(i)) regs[i] <= wdata;
      end
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_out
    assign regs_out[g*DWIDTH +: DWIDTH] = regs[g];
  end

endmodule

// File: tb/tb_ipb_modport_slave.sv
module tb_ipb_modport_slave;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int NR = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             strobe;
  logic             write;
  logic [AW-1:0]    addr;
  logic [DW-1:0]    wdata;
  logic             ack;
  logic             error;
  logic [DW-1:0]    rdata;
  logic [NR*DW-1:0] regs_out;

  always #5 clk = ~clk;

  ipb_modport_slave #(
    .DWIDTH  (DW),
    .AWIDTH  (AW),
    .NREGS   (NR),
    .ID_VALUE(32'hA5C3_0001)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .strobe  (strobe),
    .write   (write),
    .addr    (addr),
    .wdata   (wdata),
    .ack     (ack),
    .error   (error),
    .rdata   (rdata),
    .regs_out(regs_out)
  );

  typedef struct {
    bit          err;
    bit          chk_rd;
    logic [31:0] rd;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_regs [NR];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: every response cycle consumes one scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (ack || error) begin
        if (sb.size() == 0) chk("spurious_resp", {62'd0, ack, error}, 64'd0);
        else begin
          e = sb.pop_front();
          chk("ack", {63'd0, ack}, {63'd0, !e.err});
          chk("error", {63'd0, error}, {63'd0, e.err});
          if (e.chk_rd) chk("rdata", {32'd0, rdata}, {32'd0, e.rd});
        end
      end else begin
        chk("rdata_idle", {32'd0, rdata}, 64'd0);
      end
    end
  end

  task automatic txn(input bit wr, input logic [31:0] a, input logic [31:0] d,
                     input bit exp_err, input bit chk_rd, input logic [31:0] exp_rd);
    int n;
    sb.push_back('{exp_err, chk_rd, exp_rd});
    @(posedge clk); #1;
    strobe = 1'b1; write = wr; addr = a; wdata = d;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(ack || error) && n < 10);
    if (!(ack || error)) chk("timeout_resp", {63'd0, ack | error}, 64'd1);
    strobe = 1'b0; write = 1'b0; addr = '0; wdata = '0;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < NR; i++)
      chk($sformatf("%s_reg%0d", tag, i), {32'd0, regs_out[i*DW +: DW]}, {32'd0, exp_regs[i]});
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NR; i++) exp_regs[i] = '0;
    rst = 1'b1; strobe = 1'b0; write = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("reset_ack", {63'd0, ack}, 64'd0);
    chk("reset_error", {63'd0, error}, 64'd0);
    chk("reset_rdata", {32'd0, rdata}, 64'd0);
    check_regs("reset");

    for (int i = 0; i < NR; i++) txn(1'b0, 32'(i), '0, 1'b0, 1'b1, 32'h0);

    // write / read back
    txn(1'b1, 32'd3, 32'hDEADBEEF, 1'b0, 1'b0, '0);
    exp_regs[3] = 32'hDEADBEEF;
    txn(1'b0, 32'd3, '0, 1'b0, 1'b1, 32'hDEADBEEF);
    check_regs("wr3");

    // ID register
    txn(1'b0, 32'd16, '0, 1'b0, 1'b1, 32'hA5C30001);
    txn(1'b1, 32'd16, 32'h12345678, 1'b1, 1'b1, 32'h0);
    txn(1'b0, 32'd16, '0, 1'b0, 1'b1, 32'hA5C30001);
    check_regs("idwr");

    // unmapped
    txn(1'b0, 32'h1000, '0, 1'b1, 1'b1, 32'h0);
    txn(1'b1, 32'd17, 32'hCAFEF00D, 1'b1, 1'b1, 32'h0);
    txn(1'b0, 32'hFFFF_FFFF, '0, 1'b1, 1'b1, 32'h0);
    check_regs("unmap");

    // held strobe: high across 4 sampling edges -> acks on 1st and 3rd only
    sb.push_back('{1'b0, 1'b0, 32'h0});
    sb.push_back('{1'b0, 1'b0, 32'h0});
    @(posedge clk); #1;
    strobe = 1'b1; write = 1'b1; addr = 32'd5; wdata = 32'h1;
    repeat (4) @(posedge clk);
    #1 strobe = 1'b0; write = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1 chk("held_sb_empty", 64'(sb.size()), 64'd0);
    exp_regs[5] = 32'h1;
    check_regs("held");
    txn(1'b0, 32'd5, '0, 1'b0, 1'b1, 32'h1);

    // reset arriving on the same edge as a write request
    @(posedge clk); #1;
    strobe = 1'b1; write = 1'b1; addr = 32'd2; wdata = 32'hFFFF; rst = 1'b1;
    @(posedge clk); #1;
    strobe = 1'b0; write = 1'b0; rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) exp_regs[i] = '0;
    check_regs("midrst");
    txn(1'b1, 32'd2, 32'hFFFF, 1'b0, 1'b0, '0);
    exp_regs[2] = 32'hFFFF;
    txn(1'b0, 32'd2, '0, 1'b0, 1'b1, 32'hFFFF);
    check_regs("postrst");

    repeat (4) @(posedge clk);
    #1 chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
